// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize/round of a 53-bit significand into an IEEE 754 binary64 result.
// Define FP_NORM_SUBNORMAL_EN for gradual underflow; without it tiny results flush to signed zero.

module lzc_53 (
  input  logic [52:0] mant,
  output logic [5:0]  count
);
  // Highest set bit wins because it is visited last; all-zero input reports 53.
  always_comb begin
    count = 6'd53;
    for (int i = 0; i < 53; i++) begin
      if (mant[i]) count = 6'(52 - i);
    end
  end
endmodule

module fp_norm_round #(
  parameter int PIPE_STALL_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [12:0] in_exp,
  input  logic [52:0] in_mant,
  input  logic [2:0]  in_ext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [3:0]  out_flags
);

  if (PIPE_STALL_HOLD != 1) begin : g_hold_check
    $error("fp_norm_round: only PIPE_STALL_HOLD=1 is supported");
  end

  logic        en1;
  logic        en2;
  logic        s1_load;
  logic        s2_load;
  logic [5:0]  lz_count;
  logic [5:0]  norm_shamt;

  logic        s1_valid_d, s1_valid_q;
  logic        s1_sign_d,  s1_sign_q;
  logic [55:0] s1_val_d,   s1_val_q;
  logic [12:0] s1_e1_d,    s1_e1_q;
  logic        s2_valid_d, s2_valid_q;
  logic [63:0] out_result_d, out_result_q;
  logic [3:0]  out_flags_d,  out_flags_q;

  logic        rnd_up;
  logic [52:0] frac_rnd;
  logic [13:0] exp_rnd;
  logic        nrm_inexact;
  logic [63:0] res;
  logic [3:0]  flg;

`ifdef FP_NORM_SUBNORMAL_EN
  logic [13:0]  sub_sh_full;
  logic [6:0]   sub_sh;
  logic [111:0] sub_wide;
  logic         sub_sticky;
  logic         sub_up;
  logic         sub_inexact;
  logic [52:0]  sub_sig;
`endif

  // Handshake: a word moves on a port only in a cycle where valid and ready are both 1.
  // in_valid/data must be held until accepted; in_ready depends combinationally on out_ready.
  // A stage loads when it is empty or when the stage after it drains in the same cycle.
  assign en2      = !s2_valid_q || out_ready;
  assign en1      = !s1_valid_q || en2;
  assign in_ready = en1;
  assign s1_load  = in_valid && en1;
  assign s2_load  = s1_valid_q && en2;

  lzc_53 u_lzc (
    .mant  (in_mant),
    .count (lz_count)
  );

  // An all-zero mantissa normalizes the guard/round/sticky bits past the 53-bit shift.
  always_comb begin
    norm_shamt = lz_count;
    if (lz_count == 6'd53) begin
      if (in_ext[2])      norm_shamt = 6'd53;
      else if (in_ext[1]) norm_shamt = 6'd54;
      else                norm_shamt = 6'd55;
    end
  end

  always_comb begin
    s1_valid_d = en1 ? in_valid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_val_d   = s1_val_q;
    s1_e1_d    = s1_e1_q;
    if (s1_load) begin
      s1_sign_d = in_sign;
      s1_val_d  = {in_mant, in_ext} << norm_shamt;
      s1_e1_d   = in_exp - {7'd0, norm_shamt};
    end
  end

  // Stage-1 value layout: [55] hidden bit, [54:3] fraction, [2] guard, [1:0] sticky.
  always_comb begin
    rnd_up      = s1_val_q[2] && (s1_val_q[3] || s1_val_q[1] || s1_val_q[0]);
    frac_rnd    = {1'b0, s1_val_q[54:3]} + {52'd0, rnd_up};
    exp_rnd     = {s1_e1_q[12], s1_e1_q} + {13'd0, frac_rnd[52]};
    nrm_inexact = |s1_val_q[2:0];

`ifdef FP_NORM_SUBNORMAL_EN
    sub_sh_full = 14'd1 - {s1_e1_q[12], s1_e1_q};
    sub_sh      = (sub_sh_full > 14'd56) ? 7'd56 : sub_sh_full[6:0];
    sub_wide    = {s1_val_q, 56'd0} >> sub_sh;
    sub_sticky  = (|sub_wide[55:0]) || sub_wide[57] || sub_wide[56];
    sub_up      = sub_wide[58] && (sub_wide[59] || sub_sticky);
    sub_sig     = sub_wide[111:59] + {52'd0, sub_up};
    sub_inexact = sub_wide[58] || sub_sticky;
`endif

    res = {s1_sign_q, 63'd0};
    flg = 4'b0001;
    if (!s1_val_q[55]) begin
      res = {s1_sign_q, 63'd0};
      flg = 4'b0001;
    end else if ($signed(s1_e1_q) <= 13'sd0) begin
`ifdef FP_NORM_SUBNORMAL_EN
      // A carry into bit 52 lands in the exponent field as 1, the smallest normal.
      res = {s1_sign_q, 10'd0, sub_sig};
      flg = {1'b0, sub_inexact, sub_inexact, sub_sig == 53'd0};
`else
      res = {s1_sign_q, 63'd0};
      flg = 4'b0111;
`endif
    end else if ($signed(exp_rnd) >= 14'sd2047) begin
      res = {s1_sign_q, 11'h7FF, 52'd0};
      flg = 4'b1010;
    end else begin
      res = {s1_sign_q, exp_rnd[10:0], frac_rnd[51:0]};
      flg = {2'b00, nrm_inexact, 1'b0};
    end
  end

  always_comb begin
    s2_valid_d   = en2 ? s1_valid_q : s2_valid_q;
    out_result_d = s2_load ? res : out_result_q;
    out_flags_d  = s2_load ? flg : out_flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_val_q     <= 56'd0;
      s1_e1_q      <= 13'd0;
      s2_valid_q   <= 1'b0;
      out_result_q <= 64'd0;
      out_flags_q  <= 4'd0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_val_q     <= s1_val_d;
      s1_e1_q      <= s1_e1_d;
      s2_valid_q   <= s2_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed corner vectors, randomized streaming against an arithmetic
// reference model, back-pressure hold, and reset in flight.

module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [12:0] in_exp;
  logic [52:0] in_mant;
  logic [2:0]  in_ext;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_flags;

  int checks   = 0;
  int failures = 0;
  logic [67:0] exp_q[$];

  typedef struct packed {
    logic        s;
    logic [12:0] e;
    logic [52:0] m;
    logic [2:0]  x;
    logic [63:0] r;
    logic [3:0]  f;
  } vec_t;

  fp_norm_round #(.PIPE_STALL_HOLD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_ext     (in_ext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value = {m,x} * 2^(e-1023-55); round to nearest even via quotient/remainder.
  function automatic logic [67:0] ref_model(input logic s, input logic [12:0] e,
                                            input logic [52:0] m, input logic [2:0] x);
    logic [55:0]  xv;
    logic [127:0] n;
    logic [127:0] q;
    logic [127:0] r;
    int p;
    int ee;
`ifdef FP_NORM_SUBNORMAL_EN
    int t;
    logic [127:0] half;
`endif
    xv = {m, x};
    if (xv == 56'd0) return {4'b0001, s, 63'd0};
    p = 0;
    for (int i = 0; i < 56; i++) if (xv[i]) p = i;
    ee = int'($signed(e)) - (55 - p);
    n = 128'(xv) << (55 - p);
    if (ee >= 1) begin
      q = n >> 3;
      r = n - (q << 3);
      if (r > 128'd4 || (r == 128'd4 && q[0])) q = q + 128'd1;
      if (q == (128'd1 << 53)) begin
        q  = 128'd1 << 52;
        ee = ee + 1;
      end
      if (ee >= 2047) return {4'b1010, s, 11'h7FF, 52'd0};
      return {2'b00, r != 128'd0, 1'b0, s, 11'(ee), q[51:0]};
    end
`ifdef FP_NORM_SUBNORMAL_EN
    t = 3 + (((1 - ee) > 56) ? 56 : (1 - ee));
    q = n >> t;
    r = n - (q << t);
    half = 128'd1 << (t - 1);
    if (r > half || (r == half && q[0])) q = q + 128'd1;
    return {1'b0, r != 128'd0, r != 128'd0, q == 128'd0, s, q[62:0]};
`else
    return {4'b0111, s, 63'd0};
`endif
  endfunction

  task automatic drive_random_op();
    in_sign = 1'($urandom_range(0, 1));
    in_exp  = 13'($urandom_range(0, 2200)) - 13'd100;
    in_mant = {21'($urandom), 32'($urandom)} >> $urandom_range(0, 53);
    in_ext  = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 13'd0;
    in_mant = 53'd0; in_ext = 3'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    if (out_valid !== 1'b0) failures++;
    checks++; if (out_result !== 64'd0) begin failures++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
    checks++; if (out_flags !== 4'd0) begin failures++; $display("FAIL reset_out_flags: got %b expected 0000", out_flags); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[$];
    vec_t v;
    vecs.push_back('{1'b0, 13'd1023, 53'h10000000000000, 3'b000, 64'h3FF0000000000000, 4'b0000});
    vecs.push_back('{1'b0, 13'd1023, 53'h1FFFFFFFFFFFFF, 3'b100, 64'h4000000000000000, 4'b0010});
    vecs.push_back('{1'b0, 13'd1075, 53'h00000000000001, 3'b000, 64'h3FF0000000000000, 4'b0000});
    vecs.push_back('{1'b0, 13'd2047, 53'h10000000000000, 3'b000, 64'h7FF0000000000000, 4'b1010});
`ifdef FP_NORM_SUBNORMAL_EN
    vecs.push_back('{1'b0, 13'd1,    53'h08000000000000, 3'b000, 64'h0008000000000000, 4'b0000});
`else
    vecs.push_back('{1'b0, 13'd1,    53'h08000000000000, 3'b000, 64'h0000000000000000, 4'b0111});
`endif
    vecs.push_back('{1'b1, 13'd500,  53'h00000000000000, 3'b000, 64'h8000000000000000, 4'b0001});
    vecs.push_back('{1'b0, 13'd0,    53'h00000000000000, 3'b000, 64'h0000000000000000, 4'b0001});
    vecs.push_back('{1'b0, 13'd1076, 53'h00000000000000, 3'b100, 64'h3FF0000000000000, 4'b0000});
    vecs.push_back('{1'b0, 13'd2046, 53'h1FFFFFFFFFFFFF, 3'b100, 64'h7FF0000000000000, 4'b1010});
    vecs.push_back('{1'b1, 13'd1023, 53'h10000000000000, 3'b011, 64'hBFF0000000000000, 4'b0010});
    vecs.push_back('{1'b0, 13'd1023, 53'h10000000000000, 3'b100, 64'h3FF0000000000000, 4'b0010});
    vecs.push_back('{1'b0, 13'd1023, 53'h10000000000001, 3'b100, 64'h3FF0000000000002, 4'b0010});
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      v = vecs[k];
      @(negedge clk);
      in_valid = 1'b1; in_sign = v.s; in_exp = v.e; in_mant = v.m; in_ext = v.x;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", k, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL directed_early[%0d]: out_valid=%b expected 0 after 1 cycle", k, out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== v.r || out_flags !== v.f) begin
        failures++;
        $display("FAIL directed[%0d]: valid=%b result=%h flags=%b expected 1 %h %b", k, out_valid, out_result, out_flags, v.r, v.f);
      end
    end
  endtask

  task automatic test_random_stream();
    int n_ops;
    int sent;
    int got;
    logic acc;
    logic held_v;
    logic [67:0] held;
    logic [67:0] exp_v;
    n_ops = 300; sent = 0; got = 0; acc = 1'b0; held_v = 1'b0; held = '0;
    exp_q.delete();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 5000 && got < n_ops; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || {out_flags, out_result} !== held) begin
          failures++;
          $display("FAIL stall_hold: valid=%b got %h expected %h", out_valid, {out_flags, out_result}, held);
        end
      end
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < n_ops && $urandom_range(0, 4) != 0) begin
        drive_random_op();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(ref_model(in_sign, in_exp, in_mant, in_ext));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL random_unexpected: got %h with empty expected queue", {out_flags, out_result});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_flags, out_result} !== exp_v) begin
            failures++; $display("FAIL random[%0d]: got %h expected %h", got, {out_flags, out_result}, exp_v);
          end
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_flags, out_result};
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (got != n_ops) begin failures++; $display("FAIL random_count: got %0d results expected %0d", got, n_ops); end
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    logic acc;
    logic [67:0] exp_v;
    sent = 0; got = 0; acc = 1'b0;
    exp_q.delete();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (acc || !in_valid) begin
        if (sent < 4) begin
          drive_random_op();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(ref_model(in_sign, in_exp, in_mant, in_ext));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_duplicate: got %h with empty expected queue", {out_flags, out_result});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_flags, out_result} !== exp_v) begin
            failures++; $display("FAIL b2b_order[%0d]: got %h expected %h", got, {out_flags, out_result}, exp_v);
          end
        end
      end
    end
    checks++; if (got != 4) begin failures++; $display("FAIL b2b_count: got %0d results expected 4", got); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra: out_valid=%b expected 0", out_valid); end
    end

    // Fill the pipe under back-pressure, then reset with operands in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_random_op();
      in_valid = 1'b1;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_full: out_valid=%b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_flags !== 4'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: valid=%b result=%h flags=%b in_ready=%b expected 0 0 0000 1", out_valid, out_result, out_flags, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stale_after_reset: out_valid=%b expected 0", out_valid); end
    end
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 13'd1023; in_mant = 53'h10000000000000; in_ext = 3'b000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'h3FF0000000000000 || out_flags !== 4'b0000) begin
      failures++;
      $display("FAIL after_reset_op: valid=%b result=%h flags=%b expected 1 3ff0000000000000 0000", out_valid, out_result, out_flags);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_stream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
